// File: rtl/timer_pkg.sv
// Shared definitions for the timer/counter: register map, CTRL layout, modes, FSM states.
package timer_pkg;

  localparam int unsigned BUS_W = 32;

  // Word offsets on addr (processor address bits [3:2])
  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;
  localparam logic [1:0] ADDR_RSVD   = 2'd3;

  // CTRL field positions; bits above CTRL_W-1 are not stored
  localparam int unsigned CTRL_W        = 4;
  localparam int unsigned CTRL_EN_BIT   = 0;
  localparam int unsigned CTRL_MODE_LSB = 1;
  localparam int unsigned CTRL_MODE_W   = 2;
  localparam int unsigned CTRL_IM_BIT   = 3;

  // MODE encodings; 2 and 3 fall back to one-shot behaviour
  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_RELOAD  = 2'd1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_e;

endpackage

// File: rtl/timer_counter.sv
// Bus-programmable down-counter with one-shot / auto-reload modes and a maskable interrupt.
module timer_counter
  import timer_pkg::*;
#(
  parameter int unsigned COUNT_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        addr,
  input  logic              we,
  input  logic [BUS_W-1:0]  din,
  output logic [BUS_W-1:0]  dout,
  output logic              irq
);

  state_e               state_q, state_d;
  logic [CTRL_W-1:0]    ctrl_q, ctrl_d;
  logic [COUNT_W-1:0]   preset_q, preset_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic                 irq_pending_q, irq_pending_d;

  logic                 wr_ctrl;
  logic                 wr_preset;
  logic                 set_pending;
  logic                 clr_int;
  logic                 ctrl_en;
  logic [CTRL_MODE_W-1:0] ctrl_mode;

  assign wr_ctrl   = we && (addr == ADDR_CTRL);
  assign wr_preset = we && (addr == ADDR_PRESET);
  assign ctrl_en   = ctrl_q[CTRL_EN_BIT];
  assign ctrl_mode = ctrl_q[CTRL_MODE_LSB +: CTRL_MODE_W];

  // Next-state: FSM sequencing, decrementer, pending flag, then bus writes (bus wins on CTRL)
  always_comb begin
    state_d       = state_q;
    ctrl_d        = ctrl_q;
    preset_d      = preset_q;
    count_d       = count_q;
    irq_pending_d = irq_pending_q;
    set_pending   = 1'b0;
    clr_int       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ctrl_en) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!ctrl_en) begin
          state_d = ST_IDLE;
        end else if (count_q > COUNT_W'(1)) begin
          count_d = count_q - COUNT_W'(1);
        end else begin
          count_d     = '0;
          set_pending = 1'b1;
          state_d     = ST_INT;
        end
      end
      ST_INT: begin
        state_d = ST_IDLE;
        if (ctrl_mode == MODE_RELOAD) clr_int = 1'b1;
        else                          ctrl_d[CTRL_EN_BIT] = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase

    // Setting at terminal count beats any clear on the same edge
    if (set_pending)             irq_pending_d = 1'b1;
    else if (wr_ctrl || clr_int) irq_pending_d = 1'b0;

    if (wr_ctrl)   ctrl_d   = din[CTRL_W-1:0];
    if (wr_preset) preset_d = din[COUNT_W-1:0];
  end

  // State and register file; synchronous active-low reset overrides everything
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      ctrl_q        <= '0;
      preset_q      <= '0;
      count_q       <= '0;
      irq_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ctrl_q        <= ctrl_d;
      preset_q      <= preset_d;
      count_q       <= count_d;
      irq_pending_q <= irq_pending_d;
    end
  end

  // Read mux, zero-extended to the bus width
  always_comb begin
    dout = '0;
    case (addr)
      ADDR_CTRL:   dout = BUS_W'(ctrl_q);
      ADDR_PRESET: dout = BUS_W'(preset_q);
      ADDR_COUNT:  dout = BUS_W'(count_q);
      default:     dout = '0;
    endcase
  end

  // Interrupt is a pure function of flops
  assign irq = ctrl_q[CTRL_IM_BIT] & irq_pending_q;

endmodule

// File: tb/tb_timer_counter.sv
// Scoreboard bench for timer_counter: per-cycle expected COUNT/irq queued with the stimulus.
module tb_timer_counter;
  import timer_pkg::*;

  logic        clk;
  logic        reset;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];

  timer_counter dut (
    .clk  (clk),
    .reset(reset),
    .addr (addr),
    .we   (we),
    .din  (din),
    .dout (dout),
    .irq  (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr = a;
    din  = d;
    we   = 1'b1;
    tick();
    we   = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = dout;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    we    = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  function automatic void exp_cycle(input logic [31:0] cnt, input logic irq_e);
    sb_q.push_back('{"count", cnt});
    sb_q.push_back('{"irq", {31'd0, irq_e}});
  endfunction

  task automatic sb_pop(input logic [31:0] act);
    exp_t e;
    if (sb_q.size() == 0) begin
      check("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check(e.tag, act, e.val);
    end
  endtask

  // Compare n successive post-edge samples against queued expectations
  task automatic observe(input int n);
    logic [31:0] c;
    for (int i = 0; i < n; i++) begin
      rd(ADDR_COUNT, c);
      sb_pop(c);
      sb_pop({31'd0, irq});
      if (i < n - 1) tick();
    end
  endtask

  initial begin
    logic [31:0] d;
    reset = 1'b0;
    addr  = 2'd0;
    we    = 1'b0;
    din   = '0;
    tick();

    // Reset state, and ignored writes to COUNT / reserved word
    do_reset();
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), d);
      check("reset_read", d, 32'd0);
    end
    check("reset_irq", {31'd0, irq}, 32'd0);
    wr(ADDR_COUNT, 32'd5);
    wr(ADDR_RSVD, 32'd7);
    rd(ADDR_COUNT, d); check("count_wr_ignored", d, 32'd0);
    rd(ADDR_RSVD, d);  check("rsvd_read", d, 32'd0);
    wr(ADDR_CTRL, 32'hFFFF_FFF0);
    rd(ADDR_CTRL, d);  check("ctrl_upper_ignored", d, 32'd0);

    // One-shot, IM set: 3,2,1,0 then sticky irq, EN self-clears
    do_reset();
    wr(ADDR_PRESET, 32'd3);
    wr(ADDR_CTRL, 32'h9);
    exp_cycle(0, 0); exp_cycle(0, 0); exp_cycle(3, 0); exp_cycle(2, 0);
    exp_cycle(1, 0); exp_cycle(0, 1); exp_cycle(0, 1); exp_cycle(0, 1);
    observe(8);
    rd(ADDR_CTRL, d); check("ctrl_en_cleared", d, 32'h8);
    wr(ADDR_CTRL, 32'h8);
    exp_cycle(0, 0); exp_cycle(0, 0);
    observe(2);

    // Auto-reload: one-cycle pulse every 6 cycles, reload to 3
    do_reset();
    wr(ADDR_PRESET, 32'd3);
    wr(ADDR_CTRL, 32'hB);
    exp_cycle(0, 0); exp_cycle(0, 0);
    for (int p = 0; p < 3; p++) begin
      exp_cycle(3, 0); exp_cycle(2, 0); exp_cycle(1, 0);
      exp_cycle(0, 1); exp_cycle(0, 0); exp_cycle(0, 0);
    end
    observe(20);

    // Pause freezes COUNT at 6; re-enable reloads from PRESET
    do_reset();
    wr(ADDR_PRESET, 32'd10);
    wr(ADDR_CTRL, 32'h9);
    exp_cycle(0, 0); exp_cycle(0, 0); exp_cycle(10, 0); exp_cycle(9, 0);
    exp_cycle(8, 0); exp_cycle(7, 0);
    observe(6);
    wr(ADDR_CTRL, 32'h8);
    for (int i = 0; i < 4; i++) exp_cycle(6, 0);
    observe(4);
    wr(ADDR_CTRL, 32'h9);
    exp_cycle(6, 0); exp_cycle(6, 0); exp_cycle(10, 0);
    observe(3);

    // Masked terminal count: pending set, irq low, CTRL write clears pending
    do_reset();
    wr(ADDR_PRESET, 32'd2);
    wr(ADDR_CTRL, 32'h1);
    exp_cycle(0, 0); exp_cycle(0, 0); exp_cycle(2, 0); exp_cycle(1, 0);
    exp_cycle(0, 0); exp_cycle(0, 0); exp_cycle(0, 0);
    observe(7);
    check("masked_pending", {31'd0, dut.irq_pending_q}, 32'd1);
    rd(ADDR_CTRL, d); check("masked_ctrl", d, 32'h0);
    wr(ADDR_CTRL, 32'h8);
    check("masked_pending_clr", {31'd0, dut.irq_pending_q}, 32'd0);
    exp_cycle(0, 0); exp_cycle(0, 0); exp_cycle(0, 0);
    observe(3);

    // Bus CTRL write beats the INT-state EN clear on the same edge
    do_reset();
    wr(ADDR_PRESET, 32'd1);
    wr(ADDR_CTRL, 32'h9);
    exp_cycle(0, 0); exp_cycle(0, 0); exp_cycle(1, 0); exp_cycle(0, 1);
    observe(4);
    wr(ADDR_CTRL, 32'h9);
    rd(ADDR_CTRL, d); check("bus_wins_ctrl", d, 32'h9);
    exp_cycle(0, 0); exp_cycle(0, 0); exp_cycle(1, 0); exp_cycle(0, 1);
    observe(4);

    // CTRL write on the terminal-count edge leaves pending set
    do_reset();
    wr(ADDR_PRESET, 32'd1);
    wr(ADDR_CTRL, 32'h9);
    exp_cycle(0, 0); exp_cycle(0, 0); exp_cycle(1, 0);
    observe(3);
    wr(ADDR_CTRL, 32'h9);
    exp_cycle(0, 1); exp_cycle(0, 1);
    observe(2);

    // PRESET write mid-count leaves COUNT alone; reset with same-cycle CTRL write aborts
    do_reset();
    wr(ADDR_PRESET, 32'd10);
    wr(ADDR_CTRL, 32'h9);
    exp_cycle(0, 0); exp_cycle(0, 0); exp_cycle(10, 0); exp_cycle(9, 0);
    observe(4);
    wr(ADDR_PRESET, 32'd5);
    exp_cycle(8, 0); exp_cycle(7, 0);
    observe(2);
    rd(ADDR_PRESET, d); check("preset_midcount", d, 32'd5);
    reset = 1'b0;
    addr  = ADDR_CTRL;
    din   = 32'h9;
    we    = 1'b1;
    tick();
    reset = 1'b1;
    we    = 1'b0;
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), d);
      check("abort_read", d, 32'd0);
    end
    check("abort_state", 32'(dut.state_q), 32'(ST_IDLE));
    tick();
    for (int i = 0; i < 5; i++) exp_cycle(0, 0);
    observe(5);

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
